// File: rtl/dmem_byte_arbiter_if.sv
// rtl/dmem_byte_arbiter_if.sv - requester, byte-memory and status signals of dmem_byte_arbiter
interface dmem_byte_arbiter_if #(
    parameter int AW = 5
);
    logic          c_req;
    logic [1:0]    c_op;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic          c_done;
    logic [31:0]   c_rdata;

    logic          l_req;
    logic [1:0]    l_op;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic          l_done;
    logic [31:0]   l_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic          busy;

    modport slave (
        input  c_req, c_op, c_addr, c_wdata,
        input  l_req, l_op, l_addr, l_wdata,
        input  mem_rdata,
        output c_done, c_rdata, l_done, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output c_req, c_op, c_addr, c_wdata,
        output l_req, l_op, l_addr, l_wdata,
        output mem_rdata,
        input  c_done, c_rdata, l_done, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_byte_arbiter.sv
// rtl/dmem_byte_arbiter.sv - two-port word arbiter serializing big-endian byte accesses to the data memory
// Optional atomic swap (op 10) enabled by defining DMEM_ARB_SWAP_EN; otherwise op 10 is a plain read.
module dmem_byte_arbiter #(
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_byte_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;

    state_t        state_q, state_n;
    logic [2:0]    cnt_q, cnt_n;
    logic          grant_l_q, grant_l_n;
    logic          last_l_q, last_l_n;
    logic          swap_q, swap_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [31:0]   wdata_q, wdata_n;
    logic [31:0]   rd_word_q, rd_word_n;

    logic          mem_en_q, mem_en_n;
    logic          mem_we_q, mem_we_n;
    logic [AW-1:0] mem_addr_q, mem_addr_n;
    logic [7:0]    mem_wdata_q, mem_wdata_n;
    logic          c_done_q, c_done_n;
    logic          l_done_q, l_done_n;
    logic [31:0]   c_rdata_q, c_rdata_n;
    logic [31:0]   l_rdata_q, l_rdata_n;

    logic          pick_l;
    logic [1:0]    sel_op;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [1:0]    next_idx;
    logic [AW-1:0] next_addr;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        pick_l    = bus.l_req & (~bus.c_req | ~last_l_q);
        sel_op    = pick_l ? bus.l_op    : bus.c_op;
        sel_addr  = pick_l ? bus.l_addr  : bus.c_addr;
        sel_wdata = pick_l ? bus.l_wdata : bus.c_wdata;
        next_idx  = cnt_q[1:0] + 2'd1;
        next_addr = addr_q + AW'(next_idx);
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        grant_l_n   = grant_l_q;
        last_l_n    = last_l_q;
        swap_n      = swap_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rd_word_n   = rd_word_q;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        c_done_n    = 1'b0;
        l_done_n    = 1'b0;
        c_rdata_n   = c_rdata_q;
        l_rdata_n   = l_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    grant_l_n  = pick_l;
                    last_l_n   = pick_l;
                    addr_n     = sel_addr;
                    wdata_n    = sel_wdata;
                    cnt_n      = 3'd0;
`ifdef DMEM_ARB_SWAP_EN
                    swap_n     = (sel_op == OP_SWAP);
`else
                    swap_n     = 1'b0;
`endif
                    // Byte 0 is issued straight from the grant edge so the strobe lands in cycle 1.
                    mem_en_n   = 1'b1;
                    mem_addr_n = sel_addr;
                    if (sel_op == OP_WRITE) begin
                        state_n     = WR;
                        mem_we_n    = 1'b1;
                        mem_wdata_n = sel_wdata[31:24];
                    end else begin
                        state_n     = RD;
                    end
                end
            end

            RD: begin
                cnt_n = cnt_q + 3'd1;
                // Read data lags the strobe by one cycle, so capture runs one count behind.
                if (cnt_q != 3'd0)
                    rd_word_n = {rd_word_q[23:0], bus.mem_rdata};
                if (cnt_q < 3'd3) begin
                    mem_en_n   = 1'b1;
                    mem_addr_n = next_addr;
                end
                if (cnt_q == 3'd4) begin
                    cnt_n = 3'd0;
                    if (swap_q) begin
                        state_n     = WR;
                        mem_en_n    = 1'b1;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = addr_q;
                        mem_wdata_n = wdata_q[31:24];
                    end else begin
                        state_n = DONE;
                        if (grant_l_q) begin
                            l_done_n  = 1'b1;
                            l_rdata_n = rd_word_n;
                        end else begin
                            c_done_n  = 1'b1;
                            c_rdata_n = rd_word_n;
                        end
                    end
                end
            end

            WR: begin
                cnt_n = cnt_q + 3'd1;
                if (cnt_q < 3'd3) begin
                    mem_en_n    = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = next_addr;
                    mem_wdata_n = word_byte(wdata_q, next_idx);
                end else begin
                    state_n = DONE;
                    cnt_n   = 3'd0;
                    if (grant_l_q) begin
                        l_done_n = 1'b1;
                        if (swap_q)
                            l_rdata_n = rd_word_q;
                    end else begin
                        c_done_n = 1'b1;
                        if (swap_q)
                            c_rdata_n = rd_word_q;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            grant_l_q   <= 1'b0;
            last_l_q    <= 1'b1;
            swap_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rd_word_q   <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            c_done_q    <= 1'b0;
            l_done_q    <= 1'b0;
            c_rdata_q   <= 32'd0;
            l_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            grant_l_q   <= grant_l_n;
            last_l_q    <= last_l_n;
            swap_q      <= swap_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rd_word_q   <= rd_word_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            c_done_q    <= c_done_n;
            l_done_q    <= l_done_n;
            c_rdata_q   <= c_rdata_n;
            l_rdata_q   <= l_rdata_n;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.c_done    = c_done_q;
    assign bus.l_done    = l_done_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/dmem_byte_arbiter.md
# dmem_byte_arbiter

Sequencer and arbiter for the byte-wide, 32-entry data memory. Two word-level requesters share the single memory port: the processor load/store path (port C) and the loader/debug path (port L). Each 32-bit access is serialized into four big-endian byte accesses. An optional atomic swap operation serves the jump-stack exchange (read old word, write new word).

## Interface

**Parameters**
- `AW`, default 5: byte address width. The memory holds 2^AW bytes.

**Ports**
- `clk` in 1: clock. All logic acts on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `c_req` in 1: port C request. Held high with stable command until `c_done`.
- `c_op` in 2: port C operation. 00 = read, 01 = write, 10 = swap, 11 = reserved (treated as read).
- `c_addr` in AW: port C byte address of the word's most significant byte.
- `c_wdata` in 32: port C write/swap data.
- `c_done` out 1: port C one-cycle completion pulse.
- `c_rdata` out 32: port C read/swap result. Updated only when `c_done` pulses, held otherwise.
- `l_req`, `l_op`, `l_addr`, `l_wdata`, `l_done`, `l_rdata`: port L, same widths and meanings as port C.
- `mem_en` out 1: memory byte access strobe.
- `mem_we` out 1: byte write enable, valid with `mem_en`.
- `mem_addr` out AW: byte address.
- `mem_wdata` out 8: byte write data.
- `mem_rdata` in 8: byte read data. Synchronous read; valid in the cycle after a read strobe.
- `busy` out 1: high in every state except IDLE.

## Operation

- **States:** IDLE, RD, WR, DONE.
  - IDLE → RD for read, swap and reserved ops.
  - IDLE → WR for write.
  - RD → WR for swap after the 4th byte is captured.
  - RD → DONE for read, and for swap when the macro is off.
  - WR → DONE after the 4th byte.
  - DONE → IDLE always.
- **Arbitration in IDLE:**
  - One request alone is granted.
  - If both requests are high, the grant goes to the port not granted last.
  - `last_grant` resets to L, so port C wins the first tie.
  - The grant is latched, along with op, addr and wdata, at the IDLE→RD/WR edge. Later changes on requester inputs are ignored until DONE.
- **Byte counter:**
  - Byte k (0..3) uses address (addr + k) mod 2^AW. Wrap-around is required: addr 30 touches 30, 31, 0, 1.
  - Big-endian: byte 0 ↔ bits 31:24, byte 3 ↔ bits 7:0.
- **RD:** issues reads of bytes 0..3 in four consecutive cycles, then one more cycle to capture byte 3. `mem_en` is high for 4 of the 5 RD cycles.
- **WR:** writes bytes 0..3 in four consecutive cycles, with `mem_we` = 1.
- **DONE:**
  - Pulses `done` of the granted port only.
  - Drives that port's `rdata` with the assembled read word. For a write, `rdata` is not updated.
  - Requests are not sampled in DONE. A requester that still holds `req` in IDLE is treated as a new transaction.
- **Reset values:**
  - state = IDLE; `last_grant` = L.
  - `c_done` = `l_done` = 0; `c_rdata` = `l_rdata` = 0.
  - `mem_en` = `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0; `busy` = 0.
- **Reset mid-transaction:** abort at that edge. `mem_en` is 0 in the next cycle and no `done` is issued. Bytes already written stay written; no rollback.

## Timing

Cycle 0 is the IDLE cycle in which `req` is sampled high.

- **Write:** `mem_en`/`mem_we` high in cycles 1–4; `done` in cycle 5; IDLE in cycle 6. Occupancy is 6 cycles.
- **Read:** strobes in cycles 1–4; bytes captured at the ends of cycles 2–5; `done` and `rdata` valid in cycle 6; IDLE in cycle 7.
- **Swap:** reads in cycles 1–4, capture through cycle 5, writes in cycles 6–9, `done` in cycle 10. `rdata` carries the pre-write word.
- **Back-to-back:** the earliest next grant is the IDLE cycle after DONE.
- **Memory port:** no combinational path from `mem_rdata` to any output. `mem_*` outputs are registered.

## Configuration

- **`DMEM_ARB_SWAP_EN` defined:** op 10 performs an atomic read-then-write as timed above. The other port cannot be granted between the read and write phases.
- **Not defined:** op 10 behaves exactly as a read. No write occurs and `wdata` is ignored.

## Test plan

- **Write then read, port C:** write 0xDEADBEEF @ 4 gives bytes [4..7] = DE, AD, BE, EF with `c_done` in cycle 5. A following read @ 4 returns `c_rdata` = 0xDEADBEEF with `c_done` in cycle 6.
- **Wrap:** port L write 0x11223344 @ 30 gives bytes 30, 31, 0, 1 = 11, 22, 33, 44. Reading @ 30 returns 0x11223344.
- **Contention round-robin:** C and L request together from reset.
  - C is served first, then L, in the IDLE cycle after C's DONE.
  - With both held continuously, grants alternate C, L, C.
  - `l_done` never pulses during C's transaction.
- **Swap (macro on):** mem @ 8 = 0x00000010; port C swap with wdata 0x00000020. Expect `c_rdata` = 0x00000010, mem @ 8 = 0x00000020, `c_done` in cycle 10, and L's request held off until after it. With the macro off: `c_rdata` = 0x00000010 and mem is unchanged.
- **Reset mid-write:** assert `reset` in cycle 2 of a write of 0xAABBCCDD @ 0.
  - Bytes 0–1 = AA, BB; bytes 2–3 unchanged.
  - No `done`; all outputs at reset values in the next cycle; `busy` = 0.
